adc_fifo_pack_sync: RTL and testbench
=====================================

Name: adc_fifo_pack_sync

Overview:
- Single-clock FIFO that packs RATIO narrow ADC samples into one wide word and buffers DEPTH wide words.
- Generalised successor of the ADC capture FIFO:
  - write width and read width are set by parameters;
  - exact fill level is reported;
  - programmable almost-full threshold;
  - sticky overflow and underflow flags;
  - synchronous flush.
- Sits between the ADC sample interface and the bus/DMA reader in the same clock domain.

Parameters:
- WR_W, 8: narrow write data width in bits.
- RATIO, 4: narrow words per wide word; must be ≥2. RD_W = WR_W*RATIO.
- DEPTH, 128: wide-word storage depth; must be a power of 2.
- ADDR_W, 7: log2(DEPTH).
- AFULL_TH, 120: wide-word fill level at which afull asserts; must be 1..DEPTH.

Ports:
- sys_clk, in, 1: clock, rising edge.
- sys_rst_n, in, 1: reset, asynchronous, active-low.
- flush, in, 1: synchronous clear of the FIFO contents.
- wr_en, in, 1: narrow write strobe.
- din, in, WR_W: narrow write data.
- rd_en, in, 1: wide read request.
- dout, out, WR_W*RATIO: wide read data.
- valid, out, 1: dout is valid this cycle.
- empty, out, 1: no complete wide word is stored.
- full, out, 1: wide storage holds DEPTH words.
- afull, out, 1: count ≥ AFULL_TH.
- count, out, ADDR_W+1: stored wide words, range 0..DEPTH.
- pack_cnt, out, clog2(RATIO): narrow words held in the packer.
- ovf, out, 1: sticky, a write was attempted while full.
- udf, out, 1: sticky, a read was attempted while empty.

Behaviour:
- Reset: one clock (sys_clk), asynchronous active-low reset (sys_rst_n). While sys_rst_n is low:
  - all pointers, count, pack_cnt and the packer are 0;
  - dout=0, valid=0, empty=1, full=0, afull=0, ovf=0, udf=0.
  - RAM contents are not reset.
- Write accept: wr_en && !full.
  - din goes into packer lane pack_cnt, bits [pack_cnt*WR_W +: WR_W].
  - Lane 0 is the first sample and lands in the LSBs.
  - pack_cnt increments.
  - When an accepted write fills lane RATIO-1, the completed word (including this din) is written to RAM[wr_ptr], wr_ptr increments and pack_cnt returns to 0, all in the same cycle.
- full is evaluated on wide words only: count==DEPTH blocks every narrow write, including partial-packer writes.
  - A write attempted while full is dropped and sets ovf.
- Read accept: rd_en && !empty.
  - dout = RAM[rd_ptr] on the next edge, with valid=1 for one cycle.
  - rd_ptr increments.
  - Read latency is 1 cycle.
- Read while empty: valid=0 and udf is set.
- Idle / no accepted read: valid=0 and dout holds its last value.
- Pointers are ADDR_W+1 bits, binary, and wrap naturally.
  - count = wr_ptr - rd_ptr (modulo 2^(ADDR_W+1)).
  - empty = (count==0).
  - full = (count==DEPTH).
  - afull = (count ≥ AFULL_TH).
  - All flags are combinational from registered pointers and update the cycle after the pointer change.
- Simultaneous word completion and read: both are accepted and count is unchanged.
  - When count==0, a word completing this cycle is not readable this cycle; empty drops next cycle.
  - When full, the read frees a slot for the next cycle only; the write in the same cycle is still rejected.
- flush, synchronous, has priority over wr_en and rd_en:
  - clears pointers, count, packer, ovf and udf;
  - valid=0; dout holds its last value.
  - A partially packed word is discarded.
- Asynchronous reset mid-packing discards the partial word. A read in flight at reset is lost and valid returns to 0.
- No internal state machine beyond the packer lane counter. Packer states are LANE0..LANE(RATIO-1), advancing only on an accepted write.

Optional Feature:
- Macro ADC_FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - dout continuously shows RAM[rd_ptr] and valid = !empty;
  - rd_en acts as a pop, with zero read latency;
  - rd_en while empty is ignored except that it sets udf.
- Undefined: standard mode as described above, with 1-cycle read latency and a registered dout.

Test Plan:
- Reset release, then writes 0x11,0x22,0x33,0x44 → pack_cnt goes 1,2,3,0; count=1; empty=0 one cycle after the 4th write; rd_en pulse → next cycle dout=0x44332211, valid=1; then count=0, empty=1.
- Write 4*DEPTH=512 samples with no reads → full=1 at count=128; afull=1 from count=120; the 513th write is dropped and ovf=1; reading all words returns the data in order with correct lane packing.
- Hold count=5 and issue word completion and rd_en in the same cycle → count stays 5, and the data order is preserved across the pointer wrap at 128.
- rd_en while empty → valid=0, udf=1 and sticky; a following flush → udf=0, count=0, pack_cnt=0.
- Write 2 samples, then assert sys_rst_n=0 asynchronously mid-cycle → all outputs return to reset values immediately; after release, 4 new writes produce a word containing only the new data.
- With ADC_FIFO_FWFT_EN defined: write 0xAA,0xBB,0xCC,0xDD → valid=1 and dout=0xDDCCBBAA without any rd_en; rd_en → the next word, or valid=0 if the FIFO is now empty.

Source files
------------

// File: rtl/adc_fifo_pack_sync.sv
// Packs RATIO narrow ADC samples into one wide word and buffers DEPTH wide words.
// Define ADC_FIFO_FWFT_EN for first-word-fall-through reads (zero read latency).
module adc_fifo_pack_sync #(
  parameter int WR_W     = 8,
  parameter int RATIO    = 4,
  parameter int DEPTH    = 128,
  parameter int ADDR_W   = 7,
  parameter int AFULL_TH = 120
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst_n,
  input  logic                       flush,
  input  logic                       wr_en,
  input  logic [WR_W-1:0]            din,
  input  logic                       rd_en,
  output logic [WR_W*RATIO-1:0]      dout,
  output logic                       valid,
  output logic                       empty,
  output logic                       full,
  output logic                       afull,
  output logic [ADDR_W:0]            count,
  output logic [$clog2(RATIO)-1:0]   pack_cnt,
  output logic                       ovf,
  output logic                       udf
);

  localparam int RD_W   = WR_W * RATIO;
  localparam int PACK_W = $clog2(RATIO);
  localparam logic [PACK_W-1:0] LAST_LANE = PACK_W'(RATIO - 1);
  localparam logic [ADDR_W:0]   PTR_ONE   = (ADDR_W + 1)'(1);

  logic [RD_W-1:0]   mem [DEPTH];
  logic [ADDR_W:0]   wr_ptr_reg;
  logic [ADDR_W:0]   rd_ptr_reg;
  logic [PACK_W-1:0] pack_cnt_reg;
  logic [RD_W-1:0]   packer_reg;
  logic [RD_W-1:0]   word_next;
  logic              ovf_reg;
  logic              udf_reg;
  logic              wr_acc;
  logic              word_done;
  logic              rd_acc;

  assign count    = wr_ptr_reg - rd_ptr_reg;
  assign empty    = (count == '0);
  assign full     = (count == (ADDR_W + 1)'(DEPTH));
  assign afull    = (count >= (ADDR_W + 1)'(AFULL_TH));
  assign pack_cnt = pack_cnt_reg;
  assign ovf      = ovf_reg;
  assign udf      = udf_reg;

  // Full is judged on wide words only, so a full FIFO also blocks partial-packer writes.
  assign wr_acc    = wr_en && !full && !flush;
  assign word_done = wr_acc && (pack_cnt_reg == LAST_LANE);
  assign rd_acc    = rd_en && !empty && !flush;

  // The word being completed includes this cycle's din in its lane.
  generate
    for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
      assign word_next[gi*WR_W +: WR_W] =
        (pack_cnt_reg == PACK_W'(gi)) ? din : packer_reg[gi*WR_W +: WR_W];
    end
  endgenerate

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      pack_cnt_reg <= '0;
      packer_reg   <= '0;
      ovf_reg      <= 1'b0;
      udf_reg      <= 1'b0;
    end else if (flush) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      pack_cnt_reg <= '0;
      packer_reg   <= '0;
      ovf_reg      <= 1'b0;
      udf_reg      <= 1'b0;
    end else begin
      if (wr_acc) begin
        packer_reg   <= word_next;
        pack_cnt_reg <= word_done ? '0 : pack_cnt_reg + PACK_W'(1);
      end
      if (word_done) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (rd_acc)    rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      if (wr_en && full)  ovf_reg <= 1'b1;
      if (rd_en && empty) udf_reg <= 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (word_done) mem[wr_ptr_reg[ADDR_W-1:0]] <= word_next;
  end

`ifdef ADC_FIFO_FWFT_EN
  // Head word is always presented; dout is forced to 0 while nothing is stored.
  assign valid = !empty;
  assign dout  = empty ? '0 : mem[rd_ptr_reg[ADDR_W-1:0]];
`else
  logic [RD_W-1:0] dout_reg;
  logic            valid_reg;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      dout_reg  <= '0;
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= rd_acc;
      if (rd_acc) dout_reg <= mem[rd_ptr_reg[ADDR_W-1:0]];
    end
  end

  assign dout  = dout_reg;
  assign valid = valid_reg;
`endif

endmodule

// File: tb/tb_adc_fifo_pack_sync.sv
// Directed self-checking bench for adc_fifo_pack_sync (default parameters).
// Covers standard mode, or the FWFT sequence when ADC_FIFO_FWFT_EN is defined.
module tb_adc_fifo_pack_sync;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        wr_en = 1'b0;
  logic [7:0]  din = '0;
  logic        rd_en = 1'b0;
  logic [31:0] dout;
  logic        valid, empty, full, afull, ovf, udf;
  logic [7:0]  count;
  logic [1:0]  pack_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  adc_fifo_pack_sync dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .flush     (flush),
    .wr_en     (wr_en),
    .din       (din),
    .rd_en     (rd_en),
    .dout      (dout),
    .valid     (valid),
    .empty     (empty),
    .full      (full),
    .afull     (afull),
    .count     (count),
    .pack_cnt  (pack_cnt),
    .ovf       (ovf),
    .udf       (udf)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] d);
    wr_en = 1'b1;
    din   = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic rd();
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
  endtask

  function automatic logic [31:0] seq_word(input int w);
    logic [7:0] b0, b1, b2, b3;
    b0 = 8'(4*w);
    b1 = 8'(4*w + 1);
    b2 = 8'(4*w + 2);
    b3 = 8'(4*w + 3);
    return {b3, b2, b1, b0};
  endfunction

`ifndef ADC_FIFO_FWFT_EN
  logic [31:0] q[$];
  logic [31:0] acc;
  logic [31:0] exp_w;
  int          v;
`endif

  initial begin
    logic [1:0] pc_tab [4];
    pc_tab = '{2'd1, 2'd2, 2'd3, 2'd0};

    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_afull", afull, 0);
    check("rst_count", count, 0);
    check("rst_pack", pack_cnt, 0);
    check("rst_valid", valid, 0);
    check("rst_dout", dout, 0);
    check("rst_ovf_udf", {ovf, udf}, 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    step();

`ifdef ADC_FIFO_FWFT_EN
    wr(8'hAA); wr(8'hBB); wr(8'hCC);
    check("fwft_not_valid_partial", valid, 0);
    wr(8'hDD);
    check("fwft_valid", valid, 1);
    check("fwft_dout", dout, 32'hDDCCBBAA);
    wr(8'h01); wr(8'h02); wr(8'h03); wr(8'h04);
    check("fwft_count2", count, 2);
    check("fwft_head_held", dout, 32'hDDCCBBAA);
    rd();
    check("fwft_next", dout, 32'h04030201);
    check("fwft_next_valid", valid, 1);
    rd();
    check("fwft_empty_valid", valid, 0);
    check("fwft_empty", empty, 1);
    rd();
    check("fwft_udf", udf, 1);
`else
    // Basic pack and read
    for (int i = 0; i < 4; i++) begin
      wr(8'(8'h11 * (i + 1)));
      check($sformatf("pack_cnt_%0d", i), pack_cnt, pc_tab[i]);
      if (i == 2) check("empty_partial", empty, 1);
    end
    check("count_1", count, 1);
    check("empty_0", empty, 0);
    rd();
    check("rd_dout", dout, 32'h44332211);
    check("rd_valid", valid, 1);
    check("rd_count", count, 0);
    check("rd_empty", empty, 1);
    step();
    check("idle_valid", valid, 0);
    check("idle_dout_hold", dout, 32'h44332211);

    // Fill to full, afull threshold, overflow, drain in order
    for (int i = 0; i < 512; i++) begin
      wr(8'(i));
      if (i == 4*119 - 1) begin
        check("count_119", count, 119);
        check("afull_119", afull, 0);
      end
      if (i == 4*120 - 1) begin
        check("count_120", count, 120);
        check("afull_120", afull, 1);
      end
      if (i == 4*127 - 1) check("full_127", full, 0);
    end
    check("full", full, 1);
    check("count_128", count, 128);
    check("ovf_before", ovf, 0);
    wr(8'hEE);
    check("ovf_set", ovf, 1);
    check("ovf_pack", pack_cnt, 0);
    check("ovf_count", count, 128);
    for (int w = 0; w < 128; w++) begin
      rd();
      check($sformatf("drain_%0d", w), dout, seq_word(w));
    end
    check("drain_empty", empty, 1);
    check("ovf_sticky", ovf, 1);

    // Concurrent completion + read at count 5, crossing pointer wrap
    v = 8'h80;
    for (int w = 0; w < 5; w++) begin
      acc = '0;
      for (int l = 0; l < 4; l++) begin
        acc[l*8 +: 8] = 8'(v);
        wr(8'(v));
        v++;
      end
      q.push_back(acc);
    end
    check("hold_count5", count, 5);
    for (int it = 0; it < 130; it++) begin
      acc = '0;
      for (int l = 0; l < 4; l++) begin
        acc[l*8 +: 8] = 8'(v);
        din   = 8'(v);
        wr_en = 1'b1;
        rd_en = (l == 3);
        step();
        v++;
      end
      wr_en = 1'b0;
      rd_en = 1'b0;
      exp_w = q.pop_front();
      q.push_back(acc);
      check($sformatf("conc_count_%0d", it), count, 5);
      check($sformatf("conc_dout_%0d", it), dout, exp_w);
    end
    for (int w = 0; w < 5; w++) begin
      rd();
      exp_w = q.pop_front();
      check($sformatf("tail_%0d", w), dout, exp_w);
    end
    check("tail_empty", empty, 1);

    // Underflow, sticky, flush
    rd();
    check("udf_valid", valid, 0);
    check("udf_set", udf, 1);
    step();
    check("udf_sticky", udf, 1);
    wr(8'h5A);
    check("pre_flush_pack", pack_cnt, 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_udf", udf, 0);
    check("flush_ovf", ovf, 0);
    check("flush_count", count, 0);
    check("flush_pack", pack_cnt, 0);
    check("flush_valid", valid, 0);

    // Async reset mid-packing discards the partial word
    wr(8'h55); wr(8'h66);
    check("pre_rst_pack", pack_cnt, 2);
    #3 sys_rst_n = 1'b0;
    #1;
    check("arst_pack", pack_cnt, 0);
    check("arst_empty", empty, 1);
    check("arst_dout", dout, 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    wr(8'hA1); wr(8'hA2); wr(8'hA3); wr(8'hA4);
    check("post_rst_count", count, 1);
    rd();
    check("post_rst_word", dout, 32'hA4A3A2A1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
